// File: rtl/vdp_super_res_pkg.sv
// Shared types and constants for the VDP super-resolution pixel writer.
// The write queue depth is selected in the top by SUPER_RES_WRITE_FIFO_EN.
package vdp_super_res_pkg;

  localparam int SHR_WIDTH     = 64;
  localparam int SHR_HEIGHT    = 64;
  localparam int SHR_PIXELS    = SHR_WIDTH * SHR_HEIGHT;
  localparam int SHR_ADDR_STEP = 2;
  localparam int SHR_IDX_W     = $clog2(SHR_PIXELS);

  // Dot-slot phase in which the VRAM write port is available to this block
  localparam logic [1:0] SHR_DOT_WRITE = 2'd2;

  typedef struct packed {
    logic [16:0] addr;
    logic [23:0] rgb;
  } shr_wr_entry_t;

  typedef enum logic [1:0] {
    SHR_PHASE_R = 2'd0,
    SHR_PHASE_G = 2'd1,
    SHR_PHASE_B = 2'd2
  } shr_phase_e;

  typedef enum logic {
    SHR_WR_IDLE = 1'b0,
    SHR_WR_REQ  = 1'b1
  } shr_wr_state_e;

  // VRAM word address of a pixel: one 32-bit word per pixel, so always even
  function automatic logic [16:0] shr_pixel_addr(input logic [SHR_IDX_W-1:0] idx);
    return 17'(idx) * 17'(SHR_ADDR_STEP);
  endfunction

endpackage

// File: rtl/vdp_super_res_write_fifo.sv
// Write queue between pixel assembly and the VRAM arbiter.
// DEPTH=1 is a single holding register; larger depths are a circular buffer.
// Push while full is accepted only when a pop happens in the same cycle.
module vdp_super_res_write_fifo
  import vdp_super_res_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  shr_wr_entry_t din,
  output shr_wr_entry_t dout,
  output logic          empty,
  output logic          full
);

  logic do_pop_s;
  logic do_push_s;

  // Accepted push/pop: pop needs data, push needs room or a simultaneous pop
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  if (DEPTH == 1) begin : g_single

    logic          valid_r;
    shr_wr_entry_t data_r;

    // Occupancy of the holding register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_r <= 1'b0;
      end else if (clear) begin
        valid_r <= 1'b0;
      end else if (do_push_s) begin
        valid_r <= 1'b1;
      end else if (do_pop_s) begin
        valid_r <= 1'b0;
      end
    end

    // Holding register payload
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_r <= '0;
      end else if (do_push_s) begin
        data_r <= din;
      end
    end

    assign dout  = data_r;
    assign empty = ~valid_r;
    assign full  = valid_r;

  end else begin : g_ring

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    shr_wr_entry_t    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_LAST) begin
        return {PTR_W{1'b0}};
      end else begin
        return ptr + PTR_W'(1);
      end
    endfunction

    // Pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else if (clear) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (do_push_s) begin
          wr_ptr_r <= ptr_next(wr_ptr_r);
        end
        if (do_pop_s) begin
          rd_ptr_r <= ptr_next(rd_ptr_r);
        end
        case ({do_push_s, do_pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    // Entry storage; a full push+pop overwrites the slot being popped
    always_ff @(posedge clk) begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
      end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_FULL);

  end

endmodule

// File: rtl/vdp_super_res_pixel_writer.sv
// Super-resolution pixel writer: packs CPU bytes R,G,B into 24-bit pixels,
// queues them with their VRAM address and writes them out in the VDP write
// dot slot. Define SUPER_RES_WRITE_FIFO_EN for a 4-entry queue; otherwise
// a single holding register is used.
module vdp_super_res_pixel_writer
  import vdp_super_res_pkg::*;
(
  input  logic        reset,
  input  logic        clk,
  input  logic        super_high_res,
  input  logic [1:0]  dot_state,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_data_stb,
  input  logic [11:0] load_idx,
  input  logic        load_idx_stb,
  output logic        vram_wr_req,
  output logic [16:0] vram_wr_addr,
  output logic [31:0] vram_wr_data,
  input  logic        vram_wr_ack,
  output logic        busy,
  output logic        overflow
);

`ifdef SUPER_RES_WRITE_FIFO_EN
  localparam int QUEUE_DEPTH = 4;
`else
  localparam int QUEUE_DEPTH = 1;
`endif

  shr_phase_e           phase_r;
  logic [7:0]           red_r;
  logic [7:0]           green_r;
  logic [SHR_IDX_W-1:0] pixel_idx_r;
  logic                 overflow_r;

  shr_wr_state_e        state_r;
  shr_wr_state_e        state_nxt_s;
  logic                 vram_wr_req_r;
  logic [16:0]          vram_wr_addr_r;
  logic [31:0]          vram_wr_data_r;

  logic                 pixel_done_s;
  logic                 pop_s;
  logic                 drop_s;
  logic                 load_head_s;
  shr_wr_entry_t        push_entry_s;
  shr_wr_entry_t        head_s;
  logic                 q_empty_s;
  logic                 q_full_s;

  // Pixel completion, queue push/pop qualification and the pushed entry
  always_comb begin
    pixel_done_s = super_high_res & ~load_idx_stb & cpu_data_stb &
                   (phase_r == SHR_PHASE_B);
    pop_s        = super_high_res & (state_r == SHR_WR_REQ) & vram_wr_ack;
    drop_s       = pixel_done_s & q_full_s & ~pop_s;
    push_entry_s.addr = shr_pixel_addr(pixel_idx_r);
    push_entry_s.rgb  = {red_r, green_r, cpu_data};
  end

  // Byte assembly, pixel index and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r     <= SHR_PHASE_R;
      red_r       <= 8'h00;
      green_r     <= 8'h00;
      pixel_idx_r <= {SHR_IDX_W{1'b0}};
      overflow_r  <= 1'b0;
    end else if (!super_high_res) begin
      phase_r     <= SHR_PHASE_R;
      red_r       <= 8'h00;
      green_r     <= 8'h00;
      pixel_idx_r <= {SHR_IDX_W{1'b0}};
      overflow_r  <= 1'b0;
    end else if (load_idx_stb) begin
      phase_r     <= SHR_PHASE_R;
      red_r       <= 8'h00;
      green_r     <= 8'h00;
      pixel_idx_r <= load_idx;
      overflow_r  <= 1'b0;
    end else if (cpu_data_stb) begin
      case (phase_r)
        SHR_PHASE_R: begin
          red_r   <= cpu_data;
          phase_r <= SHR_PHASE_G;
        end
        SHR_PHASE_G: begin
          green_r <= cpu_data;
          phase_r <= SHR_PHASE_B;
        end
        SHR_PHASE_B: begin
          // Index advances even when the pixel is dropped
          phase_r     <= SHR_PHASE_R;
          pixel_idx_r <= pixel_idx_r + SHR_IDX_W'(1);
          if (drop_s) begin
            overflow_r <= 1'b1;
          end
        end
        default: begin
          phase_r <= SHR_PHASE_R;
        end
      endcase
    end
  end

  vdp_super_res_write_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_write_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (~super_high_res),
    .push  (pixel_done_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .empty (q_empty_s),
    .full  (q_full_s)
  );

  // Write FSM next state: request only in the write dot slot
  always_comb begin
    state_nxt_s = state_r;
    load_head_s = 1'b0;
    case (state_r)
      SHR_WR_IDLE: begin
        if (!q_empty_s && (dot_state == SHR_DOT_WRITE)) begin
          state_nxt_s = SHR_WR_REQ;
          load_head_s = 1'b1;
        end else begin
          state_nxt_s = SHR_WR_IDLE;
        end
      end
      SHR_WR_REQ: begin
        if (vram_wr_ack) begin
          state_nxt_s = SHR_WR_IDLE;
        end else begin
          state_nxt_s = SHR_WR_REQ;
        end
      end
      default: begin
        state_nxt_s = SHR_WR_IDLE;
      end
    endcase
  end

  // Write FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= SHR_WR_IDLE;
    end else if (!super_high_res) begin
      state_r <= SHR_WR_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered request outputs; address/data captured from the head on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_wr_req_r  <= 1'b0;
      vram_wr_addr_r <= 17'h00000;
      vram_wr_data_r <= 32'h00000000;
    end else if (!super_high_res) begin
      vram_wr_req_r  <= 1'b0;
      vram_wr_addr_r <= 17'h00000;
      vram_wr_data_r <= 32'h00000000;
    end else begin
      vram_wr_req_r <= (state_nxt_s == SHR_WR_REQ);
      if (load_head_s) begin
        vram_wr_addr_r <= head_s.addr;
        vram_wr_data_r <= {8'h00, head_s.rgb};
      end
    end
  end

  assign vram_wr_req  = vram_wr_req_r;
  assign vram_wr_addr = vram_wr_addr_r;
  assign vram_wr_data = vram_wr_data_r;
  assign busy         = q_full_s;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_vdp_super_res_pixel_writer.sv
// Directed bench for vdp_super_res_pixel_writer. Expected values are hand
// computed; the queue depth follows SUPER_RES_WRITE_FIFO_EN like the RTL.
module tb_vdp_super_res_pixel_writer;

`ifdef SUPER_RES_WRITE_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        reset;
  logic        clk;
  logic        super_high_res;
  logic [1:0]  dot_state;
  logic [7:0]  cpu_data;
  logic        cpu_data_stb;
  logic [11:0] load_idx;
  logic        load_idx_stb;
  logic        vram_wr_req;
  logic [16:0] vram_wr_addr;
  logic [31:0] vram_wr_data;
  logic        vram_wr_ack;
  logic        busy;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;

  vdp_super_res_pixel_writer dut (
    .reset          (reset),
    .clk            (clk),
    .super_high_res (super_high_res),
    .dot_state      (dot_state),
    .cpu_data       (cpu_data),
    .cpu_data_stb   (cpu_data_stb),
    .load_idx       (load_idx),
    .load_idx_stb   (load_idx_stb),
    .vram_wr_req    (vram_wr_req),
    .vram_wr_addr   (vram_wr_addr),
    .vram_wr_data   (vram_wr_data),
    .vram_wr_ack    (vram_wr_ack),
    .busy           (busy),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cpu_data     = b;
    cpu_data_stb = 1'b1;
    tick();
    cpu_data_stb = 1'b0;
  endtask

  task automatic load(input logic [11:0] idx);
    load_idx     = idx;
    load_idx_stb = 1'b1;
    tick();
    load_idx_stb = 1'b0;
  endtask

  task automatic push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send_byte(r);
    send_byte(g);
    send_byte(b);
  endtask

  // Open one write slot, check the request, then acknowledge it
  task automatic serve(input string tag, input logic [16:0] a, input logic [31:0] d);
    dot_state = 2'd2;
    tick();
    dot_state = 2'd0;
    check({tag, "_req"}, 64'(vram_wr_req), 64'd1);
    check({tag, "_addr"}, 64'(vram_wr_addr), 64'(a));
    check({tag, "_data"}, 64'(vram_wr_data), 64'(d));
    vram_wr_ack = 1'b1;
    tick();
    vram_wr_ack = 1'b0;
    check({tag, "_done"}, 64'(vram_wr_req), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    super_high_res = 1'b0;
    dot_state      = 2'd0;
    cpu_data       = 8'h00;
    cpu_data_stb   = 1'b0;
    load_idx       = 12'd0;
    load_idx_stb   = 1'b0;
    vram_wr_ack    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req", 64'(vram_wr_req), 64'd0);
    check("rst_addr", 64'(vram_wr_addr), 64'd0);
    check("rst_data", 64'(vram_wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset          = 1'b0;
    super_high_res = 1'b1;
    tick();

    // First pixel at index 0, request held until ack
    load(12'd0);
    push_pixel(8'h11, 8'h22, 8'h33);
    check("p0_busy", 64'(busy), 64'(DEPTH == 1));
    check("p0_noreq", 64'(vram_wr_req), 64'd0);
    dot_state = 2'd2;
    tick();
    dot_state = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("p0_hold_req", 64'(vram_wr_req), 64'd1);
      check("p0_hold_addr", 64'(vram_wr_addr), 64'h00000);
      check("p0_hold_data", 64'(vram_wr_data), 64'h00112233);
      tick();
    end
    vram_wr_ack = 1'b1;
    tick();
    vram_wr_ack = 1'b0;
    check("p0_ackd", 64'(vram_wr_req), 64'd0);
    check("p0_busy_clr", 64'(busy), 64'd0);
    // Ack while idle must not start anything
    vram_wr_ack = 1'b1;
    tick();
    vram_wr_ack = 1'b0;
    check("idle_ack", 64'(vram_wr_req), 64'd0);
    push_pixel(8'h44, 8'h55, 8'h66);
    serve("p1", 17'h00002, 32'h00445566);

    // Index wrap 4095 -> 0
    load(12'd4095);
    push_pixel(8'h01, 8'h02, 8'h03);
    serve("wrap_a", 17'h01FFE, 32'h00010203);
    push_pixel(8'h04, 8'h05, 8'h06);
    serve("wrap_b", 17'h00000, 32'h00040506);

    // Partial pixel discarded by load; load wins over a same-cycle byte
    send_byte(8'h77);
    send_byte(8'h88);
    load_idx     = 12'd10;
    load_idx_stb = 1'b1;
    cpu_data     = 8'h99;
    cpu_data_stb = 1'b1;
    tick();
    load_idx_stb = 1'b0;
    cpu_data_stb = 1'b0;
    push_pixel(8'hAA, 8'hBB, 8'hCC);
    serve("reload", 17'h00014, 32'h00AABBCC);
    dot_state = 2'd2;
    tick();
    tick();
    dot_state = 2'd0;
    check("reload_single", 64'(vram_wr_req), 64'd0);

    // Fill the queue, then overflow with one more pixel
    load(12'd0);
    for (int i = 0; i < DEPTH; i++) begin
      push_pixel(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i));
      check("fill_busy", 64'(busy), 64'(i == DEPTH - 1));
      check("fill_ovf", 64'(overflow), 64'd0);
    end
    push_pixel(8'hE0, 8'hE1, 8'hE2);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      serve("drain", 17'(2 * i), {8'h00, 8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)});
    end
    check("drain_busy", 64'(busy), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    dot_state = 2'd2;
    tick();
    dot_state = 2'd0;
    check("drain_empty", 64'(vram_wr_req), 64'd0);
    // Dropped pixel still consumed an index
    push_pixel(8'h5A, 8'h5B, 8'h5C);
    serve("after_drop", 17'(2 * (DEPTH + 1)), 32'h005A5B5C);
    load(12'd0);
    check("ovf_clr", 64'(overflow), 64'd0);

    // Request only on the cycle after dot_state==2
    load(12'h020);
    push_pixel(8'h0A, 8'h0B, 8'h0C);
    dot_state = 2'd1;
    tick();
    check("dot1", 64'(vram_wr_req), 64'd0);
    dot_state = 2'd3;
    tick();
    check("dot3", 64'(vram_wr_req), 64'd0);
    dot_state = 2'd0;
    tick();
    check("dot0", 64'(vram_wr_req), 64'd0);
    dot_state = 2'd2;
    tick();
    dot_state = 2'd0;
    check("dot2", 64'(vram_wr_req), 64'd1);
    check("dot2_addr", 64'(vram_wr_addr), 64'h00040);

    // Pixel completes in the same cycle as the ack of the pending write
    send_byte(8'hD1);
    send_byte(8'hD2);
    cpu_data     = 8'hD3;
    cpu_data_stb = 1'b1;
    vram_wr_ack  = 1'b1;
    tick();
    cpu_data_stb = 1'b0;
    vram_wr_ack  = 1'b0;
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_busy", 64'(busy), 64'(DEPTH == 1));
    serve("pp", 17'h00042, 32'h00D1D2D3);

    // Mode drop clears an in-flight request and the queue
    push_pixel(8'h61, 8'h62, 8'h63);
    dot_state = 2'd2;
    tick();
    dot_state = 2'd0;
    check("shr_pend", 64'(vram_wr_req), 64'd1);
    super_high_res = 1'b0;
    tick();
    super_high_res = 1'b1;
    check("shr_req", 64'(vram_wr_req), 64'd0);
    check("shr_busy", 64'(busy), 64'd0);
    dot_state = 2'd2;
    tick();
    tick();
    dot_state = 2'd0;
    check("shr_nowr", 64'(vram_wr_req), 64'd0);
    push_pixel(8'h71, 8'h72, 8'h73);
    serve("shr_idx0", 17'h00000, 32'h00717273);

    // Asynchronous reset during a request
    push_pixel(8'h81, 8'h82, 8'h83);
    dot_state = 2'd2;
    tick();
    dot_state = 2'd0;
    check("areset_pend", 64'(vram_wr_req), 64'd1);
    reset = 1'b1;
    #1;
    check("areset_req", 64'(vram_wr_req), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
